// File: rtl/eth_pfc_rx_pause_ctrl.sv
// Passive RX tap that decodes 802.1Qbb PFC and 802.3x PAUSE frames into per-priority pause timers.
// Optional frame statistics counters are enabled with the ETH_PFC_RX_STATS_EN macro.
module eth_pfc_rx_pause_ctrl #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned QUANTA_CYCLES = 512 / DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    input  logic                  cfg_pfc_enable,
    input  logic                  cfg_lfc_enable,
    output logic [8:0]            pause_req,
    output logic                  pause_active
`ifdef ETH_PFC_RX_STATS_EN
    ,
    output logic [15:0]           stat_pfc_frames,
    output logic [15:0]           stat_lfc_frames,
    output logic [15:0]           stat_bad_ctrl
`endif
);

    localparam int HDR_BYTES = 34;
    localparam int unsigned SUB_W = (QUANTA_CYCLES > 1) ? $clog2(QUANTA_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(QUANTA_CYCLES - 1);

    typedef enum logic {
        StHdr,
        StSkip
    } state_e;

    state_e                 r_state;
    logic [5:0]             r_cnt;
    logic [HDR_BYTES*8-1:0] r_hdr;
    logic                   r_tready;
    logic [SUB_W-1:0]       r_sub;
    logic [15:0]            r_timer [9];
    logic [8:0]             r_pause;
    logic                   r_active;

    logic [HDR_BYTES*8-1:0] w_hdr;
    logic [5:0]             w_cnt_next;
    logic                   w_beat;
    logic                   w_frame_end;
    logic                   w_tick;
    logic                   w_da_ok;
    logic                   w_etype_ok;
    logic                   w_ctrl_match;
    logic                   w_len_ok;
    logic                   w_qual;
    logic [15:0]            w_opcode;
    logic [15:0]            w_field;
    logic                   w_is_pfc;
    logic                   w_is_lfc;
    logic                   w_load_pfc;
    logic                   w_load_lfc;
    logic [15:0]            w_q [8];
    logic [15:0]            w_timer_next [9];
    logic [8:0]             w_pause_next;

    assign w_beat      = s_axis_tvalid & r_tready;
    assign w_frame_end = w_beat & s_axis_tlast;
    assign w_tick      = (r_sub == SUB_MAX);

    // Merge the current beat into the header; kept bytes are packed in arrival order.
    always_comb begin
        int pos;
        w_hdr = r_hdr;
        pos   = int'(r_cnt);
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (s_axis_tkeep[k]) begin
                if (r_state == StHdr && pos < HDR_BYTES) begin
                    w_hdr[pos*8 +: 8] = s_axis_tdata[k*8 +: 8];
                end
                pos = pos + 1;
            end
        end
        w_cnt_next = (pos >= HDR_BYTES) ? 6'(HDR_BYTES) : 6'(pos);
    end

    // Layout: DA 0-5, SA 6-11, EtherType 12-13, opcode 14-15, field 16-17, class times 18-33.
    assign w_da_ok      = (w_hdr[47:0] == 48'h01_00_00_C2_80_01);
    assign w_etype_ok   = ({w_hdr[103:96], w_hdr[111:104]} == 16'h8808);
    assign w_opcode     = {w_hdr[119:112], w_hdr[127:120]};
    assign w_field      = {w_hdr[135:128], w_hdr[143:136]};
    assign w_ctrl_match = w_da_ok & w_etype_ok;
    assign w_len_ok     = (w_cnt_next == 6'(HDR_BYTES));
    assign w_qual       = w_frame_end & ~s_axis_tuser & w_len_ok & w_ctrl_match;
    assign w_is_pfc     = (w_opcode == 16'h0101);
    assign w_is_lfc     = (w_opcode == 16'h0001);
    assign w_load_pfc   = w_qual & w_is_pfc & cfg_pfc_enable;
    assign w_load_lfc   = w_qual & w_is_lfc & cfg_lfc_enable;

    for (genvar i = 0; i < 8; i++) begin : g_quanta
        assign w_q[i] = {w_hdr[(18+2*i)*8 +: 8], w_hdr[(19+2*i)*8 +: 8]};
    end

    // A disabled frame type forces its timers to zero; a load takes priority over a tick.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_timer_next[i] = r_timer[i];
            if (!cfg_pfc_enable) begin
                w_timer_next[i] = '0;
            end else if (w_load_pfc && w_field[i]) begin
                w_timer_next[i] = w_q[i];
            end else if (w_tick && r_timer[i] != '0) begin
                w_timer_next[i] = r_timer[i] - 16'd1;
            end
        end
        w_timer_next[8] = r_timer[8];
        if (!cfg_lfc_enable) begin
            w_timer_next[8] = '0;
        end else if (w_load_lfc) begin
            w_timer_next[8] = w_field;
        end else if (w_tick && r_timer[8] != '0) begin
            w_timer_next[8] = r_timer[8] - 16'd1;
        end
        for (int i = 0; i < 9; i++) begin
            w_pause_next[i] = (w_timer_next[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StHdr;
            r_cnt    <= '0;
            r_hdr    <= '0;
            r_tready <= 1'b0;
        end else begin
            r_tready <= 1'b1;
            if (w_beat) begin
                if (s_axis_tlast) begin
                    r_state <= StHdr;
                    r_cnt   <= '0;
                end else if (r_state == StHdr) begin
                    r_hdr <= w_hdr;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == 6'(HDR_BYTES)) begin
                        r_state <= StSkip;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub    <= '0;
            r_pause  <= '0;
            r_active <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_timer[i] <= '0;
            end
        end else begin
            r_sub    <= w_tick ? '0 : r_sub + 1'b1;
            r_pause  <= w_pause_next;
            r_active <= |w_pause_next;
            for (int i = 0; i < 9; i++) begin
                r_timer[i] <= w_timer_next[i];
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign pause_req     = r_pause;
    assign pause_active  = r_active;

`ifdef ETH_PFC_RX_STATS_EN
    logic [15:0] r_stat_pfc;
    logic [15:0] r_stat_lfc;
    logic [15:0] r_stat_bad;
    logic        w_bad;

    // Bad control frame: DA/EtherType present and matching but errored, short or unknown opcode.
    assign w_bad = w_frame_end & (w_cnt_next >= 6'd14) & w_ctrl_match &
                   (s_axis_tuser | ~w_len_ok | ~(w_is_pfc | w_is_lfc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pfc <= '0;
            r_stat_lfc <= '0;
            r_stat_bad <= '0;
        end else begin
            if (w_load_pfc && r_stat_pfc != 16'hFFFF) begin
                r_stat_pfc <= r_stat_pfc + 16'd1;
            end
            if (w_load_lfc && r_stat_lfc != 16'hFFFF) begin
                r_stat_lfc <= r_stat_lfc + 16'd1;
            end
            if (w_bad && r_stat_bad != 16'hFFFF) begin
                r_stat_bad <= r_stat_bad + 16'd1;
            end
        end
    end

    assign stat_pfc_frames = r_stat_pfc;
    assign stat_lfc_frames = r_stat_lfc;
    assign stat_bad_ctrl   = r_stat_bad;
`endif

endmodule
